// File: rtl/word_gather_stage_pkg.sv
// Shared defaults and sizing helpers for the word gather stage.
//   DEFAULT_WIDTH / DEFAULT_NUM_WORDS : default word width and words per vector
//   count_width()                      : bits needed for a 0..NUM_WORDS word counter
//   count_t                            : counter type for the default configuration
package word_gather_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 16;
  localparam int unsigned DEFAULT_NUM_WORDS = 8;
  localparam int unsigned DEFAULT_COUNT_W   = $clog2(DEFAULT_NUM_WORDS + 1);

  typedef logic [DEFAULT_COUNT_W-1:0] count_t;

  // Counter must also hold NUM_WORDS itself, which marks the FULL state.
  function automatic int unsigned count_width(input int unsigned num_words);
    return $clog2(num_words + 1);
  endfunction

endpackage

// File: rtl/word_gather_stage_if.sv
// Word-serial valid/ready input stream of the gather stage.
//   in_data  : input word
//   in_valid : in_data valid
//   in_ready : stage can accept in_data this cycle
// master = word producer, slave = gather stage.
interface word_gather_if
  import word_gather_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/word_gather_stage.sv
// Serial-to-parallel input stage: gathers NUM_WORDS words from a valid/ready
// stream into a vector and holds it on out/valid_out until consumed by en.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush of partial vector and held output
//   en         : downstream enable; held vector consumed on a posedge with en=1
//   in_if      : word stream (in_data, in_valid, in_ready)
//   out        : assembled vector, out[0] = first word accepted
//   valid_out  : out holds an unconsumed vector
module word_gather_stage
  import word_gather_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  word_gather_if.slave      in_if,
  output logic [WIDTH-1:0]  out [NUM_WORDS],
  output logic              valid_out
);

  localparam int unsigned   CW   = count_width(NUM_WORDS);
  localparam logic [CW-1:0] FULL = CW'(NUM_WORDS);
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic             valid_d;
  logic             load_out;
  logic             accept;
  logic             out_free;
  logic [WIDTH-1:0] slots [NUM_WORDS];
  logic [WIDTH-1:0] out_d [NUM_WORDS];

  // Ready depends on state only: blocked only while a complete vector waits in the slots.
  assign in_if.in_ready = (count != FULL);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign out_free       = !valid_out || en;

  // Counter / output-valid next state.
  always_comb begin
    count_d  = count;
    valid_d  = valid_out;
    load_out = 1'b0;
    if (clr) begin
      count_d = '0;
      valid_d = 1'b0;
    end else begin
      // A held vector is consumed on any en edge unless replaced below.
      if (en) valid_d = 1'b0;
      if (count == FULL) begin
        if (en) begin
          load_out = 1'b1;
          count_d  = '0;
          valid_d  = 1'b1;
        end
      end else if (accept) begin
        if (count == LAST) begin
          if (out_free) begin
            load_out = 1'b1;
            count_d  = '0;
            valid_d  = 1'b1;
          end else begin
            count_d = FULL;
          end
        end else begin
          count_d = count + CW'(1);
        end
      end
    end
  end

  // Final word bypasses the slots so the vector loads on the same edge it completes.
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      out_d[i] = slots[i];
    end
    if (accept) out_d[NUM_WORDS-1] = in_if.in_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      valid_out <= 1'b0;
    end else begin
      count     <= count_d;
      valid_out <= valid_d;
    end
  end

  // Assembly slots and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        slots[i] <= '0;
        out[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (accept && !clr && (count == CW'(i))) slots[i] <= in_if.in_data;
        if (load_out) out[i] <= out_d[i];
      end
    end
  end

endmodule

// File: tb/tb_word_gather_stage.sv
// Self-checking bench for word_gather_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based vector model.
module tb_word_gather_stage;
  import word_gather_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic en;
  logic [W-1:0] dut_out [N];
  logic valid_out;

  word_gather_if #(.WIDTH(W)) bus ();

  word_gather_stage #(.WIDTH(W), .NUM_WORDS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .in_if     (bus),
    .out       (dut_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words collect in a queue; a complete vector either goes
  // straight to the held output or waits (stage blocked) until en frees the output.
  logic [W-1:0] m_part [$];
  logic [W-1:0] m_pend [N];
  logic [W-1:0] m_held [N];
  bit           m_pend_v;
  bit           m_valid;
  bit           m_free;
  bit           m_loaded;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_part.delete();
      m_pend_v = 1'b0;
      m_valid  = 1'b0;
      for (int i = 0; i < N; i++) m_held[i] = '0;
    end else if (clr) begin
      m_part.delete();
      m_pend_v = 1'b0;
      m_valid  = 1'b0;
    end else begin
      m_free   = !m_valid || en;
      m_loaded = 1'b0;
      if (m_pend_v) begin
        if (en) begin
          m_held   = m_pend;
          m_pend_v = 1'b0;
          m_loaded = 1'b1;
        end
      end else if (bus.in_valid) begin
        m_part.push_back(bus.in_data);
        if (m_part.size() == N) begin
          for (int i = 0; i < N; i++) m_pend[i] = m_part[i];
          m_part.delete();
          if (m_free) begin
            m_held   = m_pend;
            m_loaded = 1'b1;
          end else begin
            m_pend_v = 1'b1;
          end
        end
      end
      if (m_loaded) m_valid = 1'b1;
      else if (en)  m_valid = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  int dut_consumed = 0;
  int bad_idx;

  always @(negedge clk) begin
    check("in_ready", 64'(bus.in_ready), 64'(!m_pend_v));
    check("valid_out", 64'(valid_out), 64'(m_valid));
    if (m_valid) begin
      checks++;
      bad_idx = -1;
      for (int i = N - 1; i >= 0; i--) if (dut_out[i] !== m_held[i]) bad_idx = i;
      if (bad_idx >= 0) begin
        errors++;
        $display("FAIL out_vec[%0d]: got 0x%0h expected 0x%0h at %0t",
                 bad_idx, dut_out[bad_idx], m_held[bad_idx], $time);
      end
    end
    if (rst_n && !clr && valid_out && en) dut_consumed++;
  end

  bit rand_en = 1'b0;

  // Offer one word, holding it until the stage accepts it (bounded).
  task automatic send(input logic [W-1:0] w);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int k = 0; k < 64; k++) begin
      if (rand_en) en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int unsigned dot4();
    int unsigned s = 0;
    for (int i = 0; i < N; i += 2) s += int'(dut_out[i]) * int'(dut_out[i+1]);
    return s;
  endfunction

  initial begin
    rst_n        = 1'b0;
    clr          = 1'b0;
    en           = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    idle(3);
    check("reset_valid", 64'(valid_out), 64'(0));
    check("reset_out0", 64'(dut_out[0]), 64'(0));
    rst_n = 1'b1;
    idle(1);
    check("reset_ready", 64'(bus.in_ready), 64'(1));

    // 1: reset mid-assembly discards partial words.
    for (int w = 1; w <= 3; w++) send(W'(w));
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 64'(valid_out), 64'(0));
    check("midrst_ready", 64'(bus.in_ready), 64'(1));
    idle(1);
    rst_n = 1'b1;
    for (int w = 11; w <= 18; w++) send(W'(w));
    check("fresh_valid", 64'(valid_out), 64'(1));
    check("fresh_out0", 64'(dut_out[0]), 64'(11));
    check("fresh_out7", 64'(dut_out[7]), 64'(18));
    idle(2);

    // 2: back-to-back stream 1..16.
    for (int w = 1; w <= 16; w++) begin
      send(W'(w));
      if (w == 8) begin
        check("s2_v1_valid", 64'(valid_out), 64'(1));
        check("s2_v1_out0", 64'(dut_out[0]), 64'(1));
        check("s2_v1_out7", 64'(dut_out[7]), 64'(8));
        check("s2_v1_dot", 64'(dot4()), 64'(100));
      end
      if (w == 9) check("s2_gap_valid", 64'(valid_out), 64'(0));
      if (w == 16) begin
        check("s2_v2_out0", 64'(dut_out[0]), 64'(9));
        check("s2_v2_dot", 64'(dot4()), 64'(644));
      end
    end
    idle(2);

    // 3: stall from word 5; stage fills and blocks, then drains in order.
    for (int w = 1; w <= 16; w++) begin
      if (w == 5) en = 1'b0;
      send(W'(w));
    end
    idle(2);
    check("s3_full_ready", 64'(bus.in_ready), 64'(0));
    check("s3_hold_valid", 64'(valid_out), 64'(1));
    check("s3_hold_out0", 64'(dut_out[0]), 64'(1));
    check("s3_hold_out7", 64'(dut_out[7]), 64'(8));
    en = 1'b1;
    idle(1);
    check("s3_next_valid", 64'(valid_out), 64'(1));
    check("s3_next_out0", 64'(dut_out[0]), 64'(9));
    check("s3_next_out7", 64'(dut_out[7]), 64'(16));
    check("s3_next_ready", 64'(bus.in_ready), 64'(1));
    idle(1);
    check("s3_drained", 64'(valid_out), 64'(0));

    // 4: idle cycles between words.
    for (int w = 0; w < 8; w++) begin
      send(W'(16'h30 + w));
      if (w != 7) idle(1);
    end
    check("s4_out0", 64'(dut_out[0]), 64'(16'h30));
    check("s4_out3", 64'(dut_out[3]), 64'(16'h33));
    check("s4_out7", 64'(dut_out[7]), 64'(16'h37));
    idle(2);

    // 5: clr discards a partial vector.
    for (int w = 0; w < 5; w++) send(W'(16'h50 + w));
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("s5_clr_valid", 64'(valid_out), 64'(0));
    check("s5_clr_ready", 64'(bus.in_ready), 64'(1));
    for (int w = 0; w < 8; w++) send(W'(16'hA0 + w));
    check("s5_out0", 64'(dut_out[0]), 64'(16'hA0));
    check("s5_out4", 64'(dut_out[4]), 64'(16'hA4));
    check("s5_out7", 64'(dut_out[7]), 64'(16'hA7));
    idle(3);

    // 6: random en stalls and gaps; every vector sent is consumed exactly once.
    dut_consumed = 0;
    rand_en = 1'b1;
    for (int v = 0; v < 20; v++) begin
      for (int w = 0; w < N; w++) begin
        if ($urandom_range(0, 3) == 0) begin
          en = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        send(W'($urandom));
      end
    end
    rand_en = 1'b0;
    en = 1'b1;
    idle(4);
    check("s6_vectors", 64'(dut_consumed), 64'(20));

    // Random traffic including clr, checked cycle by cycle against the model.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data  = W'($urandom);
      en           = ($urandom_range(0, 2) != 0);
      clr          = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    en  = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
